tri_logic_pipe: RTL and testbench

TRI_LOGIC_PIPE -- requirements
Module: tri_logic_pipe

---
 rtl/tri_logic_pipe_if.sv | 25 ++
 rtl/tri_logic_pipe.sv | 90 +++++++++
 tb/tb_tri_logic_pipe.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_logic_pipe_if.sv
// Handshake bundle for tri_logic_pipe: operand-set input channel, result output
// channel and the delivered-result counter.
interface tri_logic_pipe_if #(
    parameter int WIDTH = 1,
    parameter int NIN   = 3
);
    logic                   in_vld;
    logic                   in_rdy;
    logic [0:NIN*WIDTH-1]   din;
    logic [0:NIN-1]         mask;
    logic                   out_vld;
    logic                   out_rdy;
    logic [0:WIDTH-1]       y;
    logic [7:0]             res_cnt;

    modport master (
        output in_vld, din, mask, out_rdy,
        input  in_rdy, out_vld, y, res_cnt
    );

    modport slave (
        input  in_vld, din, mask, out_rdy,
        output in_rdy, out_vld, y, res_cnt
    );
endinterface

// File: rtl/tri_logic_pipe.sv
// Masked bitwise N-input logic reduction (NAND/AND/NOR/OR/XOR/XNOR) feeding an
// elastic valid/ready register pipeline of STAGES stages.
module tri_logic_pipe #(
    parameter int WIDTH  = 1,
    parameter int NIN    = 3,
    parameter int OP     = 0,
    parameter int STAGES = 1
) (
    input  logic         nclk,
    input  logic         rst,
    tri_logic_pipe_if.slave bus
);

    localparam bit IS_AND = (OP == 0) || (OP == 1);
    localparam bit IS_OR  = (OP == 2) || (OP == 3);
    localparam bit INVERT = (OP == 0) || (OP == 2) || (OP == 5);
    // A masked-off operand is replaced by the identity of the base operator.
    localparam logic [0:WIDTH-1] IDENT = {WIDTH{IS_AND}};

    logic [0:WIDTH-1] comb_y;
    logic [STAGES-1:0] v;
    logic [0:WIDTH-1] data [STAGES];
    logic [STAGES-1:0] stage_rdy;
    logic [STAGES-1:0] src_vld;
    logic [0:WIDTH-1] src_dat [STAGES];
    logic [7:0] res_cnt_q;

    // NOTE: every variable gets a default before any conditional use, so no latch is inferred.
    always_comb begin
        logic [0:WIDTH-1] red;
        logic [0:WIDTH-1] opnd;
        red  = IDENT;
        opnd = IDENT;
        for (int k = 0; k < NIN; k++) begin
            opnd = bus.mask[k] ? bus.din[k*WIDTH +: WIDTH] : IDENT;
            if (IS_AND)     red = red & opnd;
            else if (IS_OR) red = red | opnd;
            else            red = red ^ opnd;
        end
        comb_y = INVERT ? ~red : red;
    end

    // A stage may load when any stage from it to the output is empty, or the
    // output pops: the whole full tail then shifts together with no bubble.
    always_comb begin
        logic tail_full;
        tail_full = 1'b1;
        stage_rdy = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            tail_full    = tail_full & v[s];
            stage_rdy[s] = bus.out_rdy | ~tail_full;
        end
    end

    always_comb begin
        src_vld    = '0;
        src_vld[0] = bus.in_vld;
        src_dat[0] = comb_y;
        for (int s = 1; s < STAGES; s++) begin
            src_vld[s] = v[s-1];
            src_dat[s] = data[s-1];
        end
    end

    // NOTE: the data registers are reset too, so y reads 0 during reset instead of stale contents.
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int s = 0; s < STAGES; s++) data[s] <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (stage_rdy[s]) begin
                    v[s] <= src_vld[s];
                    if (src_vld[s]) data[s] <= src_dat[s];
                end
            end
        end
    end

    always_ff @(posedge nclk or posedge rst) begin
        if (rst)                           res_cnt_q <= 8'd0;
        else if (v[STAGES-1] && bus.out_rdy) res_cnt_q <= res_cnt_q + 8'd1;
    end

    assign bus.in_rdy  = stage_rdy[0];
    assign bus.out_vld = v[STAGES-1];
    assign bus.y       = data[STAGES-1];
    assign bus.res_cnt = res_cnt_q;

endmodule

// File: tb/tb_tri_logic_pipe.sv
// Self-checking bench: six tri_logic_pipe instances (every OP, STAGES 1..4) share
// one stimulus stream and are compared against a queue-based reference model.
module tb_tri_logic_pipe;

    localparam int NI = 6;
    localparam int W  = 4;
    localparam int N  = 3;
    localparam logic [0:NI-1][2:0] STG = {3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3};

    logic nclk = 1'b0;
    logic rst  = 1'b0;
    always #5 nclk = ~nclk;

    logic             in_vld  = 1'b0;
    logic             out_rdy = 1'b0;
    logic [0:N*W-1]   din     = '0;
    logic [0:N-1]     mask    = '0;

    logic             in_rdy_w  [NI];
    logic             out_vld_w [NI];
    logic [0:W-1]     y_w       [NI];
    logic [7:0]       cnt_w     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        tri_logic_pipe_if #(.WIDTH(W), .NIN(N)) bus ();
        assign bus.in_vld  = in_vld;
        assign bus.din     = din;
        assign bus.mask    = mask;
        assign bus.out_rdy = out_rdy;
        assign in_rdy_w[g]  = bus.in_rdy;
        assign out_vld_w[g] = bus.out_vld;
        assign y_w[g]       = bus.y;
        assign cnt_w[g]     = bus.res_cnt;
        tri_logic_pipe #(.WIDTH(W), .NIN(N), .OP(g), .STAGES(int'(STG[g]))) dut (
            .nclk (nclk),
            .rst  (rst),
            .bus  (bus)
        );
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: per instance, a FIFO of {expected result, accept cycle}.
    logic [0:W-1] m_y [NI][16];
    int           m_t [NI][16];
    int           m_rd [NI];
    int           m_n  [NI];
    int           m_cnt[NI];
    int           cyc = 0;
    logic         acc_s [NI];
    logic         pop_s [NI];

    typedef struct packed {
        logic [0:N-1]          mask;
        logic [0:N*W-1]        din;
        logic [0:NI-1][0:W-1]  exp;
    } vec_t;
    vec_t vecs [7];

    function automatic int stg(int g);
        return int'(STG[g]);
    endfunction

    // Count included ones per bit column, then apply the operator's rule.
    function automatic logic [0:W-1] ref_y(int op, logic [0:N-1] m, logic [0:N*W-1] d);
        logic [0:W-1] r;
        logic b;
        int ones, used;
        r = '0;
        for (int i = 0; i < W; i++) begin
            ones = 0;
            used = 0;
            for (int k = 0; k < N; k++) begin
                if (m[k]) begin
                    used++;
                    ones += int'(d[k*W+i]);
                end
            end
            case (op)
                0, 1:    b = (ones == used);
                2, 3:    b = (ones > 0);
                default: b = ones[0];
            endcase
            r[i] = (op == 0 || op == 2 || op == 5) ? ~b : b;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int g = 0; g < NI; g++) begin
            m_rd[g]  = 0;
            m_n[g]   = 0;
            m_cnt[g] = 0;
        end
    endtask

    // One clock cycle: compare at the falling edge, update the model at the rising edge.
    task automatic step();
        int wr;
        logic exp_vld;
        @(negedge nclk);
        for (int g = 0; g < NI; g++) begin
            exp_vld = (m_n[g] > 0) && ((cyc - m_t[g][m_rd[g]]) >= stg(g) - 1);
            check($sformatf("in_rdy[%0d]", g), 32'(in_rdy_w[g]),
                  32'((m_n[g] < stg(g)) || out_rdy));
            check($sformatf("out_vld[%0d]", g), 32'(out_vld_w[g]), 32'(exp_vld));
            if (exp_vld)
                check($sformatf("y[%0d]", g), 32'(y_w[g]), 32'(m_y[g][m_rd[g]]));
            check($sformatf("res_cnt[%0d]", g), 32'(cnt_w[g]), 32'(m_cnt[g] % 256));
            acc_s[g] = in_vld && in_rdy_w[g];
            pop_s[g] = out_vld_w[g] && out_rdy;
        end
        @(posedge nclk);
        cyc++;
        for (int g = 0; g < NI; g++) begin
            if (pop_s[g] && m_n[g] > 0) begin
                m_rd[g] = (m_rd[g] + 1) % 16;
                m_n[g]--;
                m_cnt[g]++;
            end
            if (acc_s[g]) begin
                wr = (m_rd[g] + m_n[g]) % 16;
                m_y[g][wr] = ref_y(g, mask, din);
                m_t[g][wr] = cyc;
                m_n[g]++;
            end
        end
        #1;
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and checks it acts at once.
    task automatic do_reset();
        in_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_in_rdy[%0d]", g), 32'(in_rdy_w[g]), 32'd1);
            check($sformatf("rst_out_vld[%0d]", g), 32'(out_vld_w[g]), 32'd0);
            check($sformatf("rst_y[%0d]", g), 32'(y_w[g]), 32'd0);
            check($sformatf("rst_res_cnt[%0d]", g), 32'(cnt_w[g]), 32'd0);
        end
        model_clear();
        @(posedge nclk);
        #3 rst = 1'b0;
        @(posedge nclk);
        #1;
    endtask

    initial begin
        logic [0:NI-1] seen;
        logic [0:W-1]  set_y [6];
        int acc_n;

        vecs[0] = '{mask: 3'b111, din: 12'b1111_1111_0111,
                    exp: {4'b1000, 4'b0111, 4'b0000, 4'b1111, 4'b0111, 4'b1000}};
        vecs[1] = '{mask: 3'b000, din: 12'b1010_0110_1100,
                    exp: {4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111}};
        vecs[2] = '{mask: 3'b010, din: 12'b0000_0101_1111,
                    exp: {4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b0101, 4'b1010}};
        vecs[3] = '{mask: 3'b101, din: 12'b1100_0000_1010,
                    exp: {4'b0111, 4'b1000, 4'b0001, 4'b1110, 4'b0110, 4'b1001}};
        vecs[4] = '{mask: 3'b011, din: 12'b1111_0011_0101,
                    exp: {4'b1110, 4'b0001, 4'b1000, 4'b0111, 4'b0110, 4'b1001}};
        vecs[5] = '{mask: 3'b110, din: 12'b1001_0110_1111,
                    exp: {4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000}};
        vecs[6] = '{mask: 3'b100, din: 12'b0110_1111_1111,
                    exp: {4'b1001, 4'b0110, 4'b1001, 4'b0110, 4'b0110, 4'b1001}};

        @(posedge nclk);
        #1;
        do_reset();

        // Directed vectors: one set at a time, drained through every instance.
        for (int v = 0; v < 7; v++) begin
            seen    = '0;
            in_vld  = 1'b1;
            out_rdy = 1'b1;
            din     = vecs[v].din;
            mask    = vecs[v].mask;
            for (int k = 0; k < 6; k++) begin
                step();
                if (k == 0) begin
                    in_vld = 1'b0;
                    din    = 12'($urandom);
                    mask   = 3'($urandom);
                end
                if (v == 0 && k == 0) check("vec0_res_cnt_before_pop", 32'(cnt_w[0]), 32'd0);
                if (v == 0 && k == 1) check("vec0_res_cnt_after_pop", 32'(cnt_w[0]), 32'd1);
                for (int g = 0; g < NI; g++) begin
                    if (out_vld_w[g] && !seen[g]) begin
                        check($sformatf("vec%0d_y[%0d]", v, g), 32'(y_w[g]), 32'(vecs[v].exp[g]));
                        seen[g] = 1'b1;
                    end
                end
            end
            for (int g = 0; g < NI; g++)
                check($sformatf("vec%0d_seen[%0d]", v, g), 32'(seen[g]), 32'd1);
        end

        // Backpressure fill on the 3-stage instance, then ordered drain.
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        acc_n   = 0;
        for (int k = 0; k < 6; k++) begin
            din      = 12'($urandom);
            mask     = 3'($urandom);
            set_y[k] = ref_y(5, mask, din);
            step();
            if (acc_s[5]) acc_n++;
        end
        check("fill_accepted", 32'(acc_n), 32'd3);
        check("fill_in_rdy", 32'(in_rdy_w[5]), 32'd0);
        check("fill_out_vld", 32'(out_vld_w[5]), 32'd1);
        check("fill_y_frozen", 32'(y_w[5]), 32'(set_y[0]));
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int k = 1; k < 3; k++) begin
            step();
            check($sformatf("drain_vld%0d", k), 32'(out_vld_w[5]), 32'd1);
            check($sformatf("drain_y%0d", k), 32'(y_w[5]), 32'(set_y[k]));
        end
        step();
        check("drain_empty", 32'(out_vld_w[5]), 32'd0);
        repeat (4) step();

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 2000; k++) begin
            in_vld  = ($urandom % 10) < 7;
            out_rdy = ($urandom % 10) < 6;
            din     = 12'($urandom);
            mask    = 3'($urandom);
            step();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (5) step();

        // Sustained throughput: 300 sets with out_rdy held high.
        do_reset();
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        acc_n   = 0;
        for (int k = 0; k < 300; k++) begin
            din  = 12'($urandom);
            mask = 3'($urandom);
            step();
            if (acc_s[1]) acc_n++;
        end
        in_vld = 1'b0;
        repeat (5) step();
        check("stream_accepted", 32'(acc_n), 32'd300);
        for (int g = 0; g < NI; g++)
            check($sformatf("stream_res_cnt[%0d]", g), 32'(cnt_w[g]), 32'd44);

        // Reset with two sets in flight; nothing stale may emerge afterwards.
        in_vld  = 1'b1;
        out_rdy = 1'b0;
        repeat (2) begin
            din  = 12'($urandom);
            mask = 3'($urandom);
            step();
        end
        do_reset();
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("post_rst_vld%0d", k), 32'(out_vld_w[3]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
